program_loader: RTL and testbench

Byte-stream program loader that writes framed program images into the computer's memory and holds the CPU in reset while loading. It consumes bytes from an upstream byte source (UART receiver or bench driver) over a valid/ready handshake, parses a fixed frame (header, 16-bit load address, length, payload, optional checksum), and issues one-cycle write strobes on the memory write port. It drives the CPU hold that `computer` ORs into the CPU reset, and sits between the serial front end and the ROM/RAM write port. This is the hardware counterpart of preloading the ROM image from a hex file.

---
 rtl/program_loader_if.sv | 29 ++
 rtl/program_loader.sv | 144 ++++++++++++++
 tb/tb_program_loader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream and memory-write-port signals of program_loader.
// master: the loader side; slave: the byte source / memory / CPU side.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  rx_valid_i;
  logic [DATA_WIDTH-1:0] rx_data_i;
  logic                  rx_ready_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic                  cpu_hold_o;
  logic                  busy_o;
  logic                  load_done_o;
  logic                  load_error_o;

  modport master (
    input  rx_valid_i, rx_data_i,
    output rx_ready_o, mem_we_o, mem_addr_o, mem_data_o,
    output cpu_hold_o, busy_o, load_done_o, load_error_o
  );

  modport slave (
    output rx_valid_i, rx_data_i,
    input  rx_ready_o, mem_we_o, mem_addr_o, mem_data_o,
    input  cpu_hold_o, busy_o, load_done_o, load_error_o
  );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream program loader: header, addr hi/lo, length, payload[, checksum].
// Define PROGRAM_LOADER_CHECKSUM_EN to add the trailing checksum byte and load_error_o.
module program_loader #(
  parameter int unsigned          ADDR_WIDTH  = 16,
  parameter int unsigned          DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] HEADER_BYTE = 8'hA5
) (
  input logic              clk,
  input logic              reset,
  program_loader_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StAddrHi,
    StAddrLo,
    StLen,
    StData
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , StCheck
`endif
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] addr_hi_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH:0]   cnt_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic                  cpu_hold_q;
  logic                  done_q;
  logic                  accept;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] sum_next;
  logic                  error_q;

  // Kept at DATA_WIDTH so the carry out of the byte sum is discarded.
  assign sum_next          = acc_q + bus.rx_data_i;
  assign bus.load_error_o  = error_q;
`else
  assign bus.load_error_o  = 1'b0;
`endif

  // The only stall is the write cycle of a non-final payload byte.
  assign bus.rx_ready_o  = !((state_q == StData) && mem_we_q);
  assign accept          = bus.rx_valid_i && bus.rx_ready_o;
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_data_o  = mem_data_q;
  assign bus.cpu_hold_o  = cpu_hold_q;
  assign bus.load_done_o = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_hi_q  <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      acc_q      <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (accept) begin
        case (state_q)
          StIdle: begin
            if (bus.rx_data_i == HEADER_BYTE) begin
              state_q    <= StAddrHi;
              cpu_hold_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              acc_q      <= '0;
              error_q    <= 1'b0;
`endif
            end
          end
          StAddrHi: begin
            addr_hi_q <= bus.rx_data_i;
            state_q   <= StAddrLo;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            acc_q     <= sum_next;
`endif
          end
          StAddrLo: begin
            addr_q  <= ADDR_WIDTH'({addr_hi_q, bus.rx_data_i});
            state_q <= StLen;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            acc_q   <= sum_next;
`endif
          end
          StLen: begin
            // A zero length byte encodes a full 2^DATA_WIDTH payload.
            cnt_q   <= (bus.rx_data_i == '0) ? {1'b1, {DATA_WIDTH{1'b0}}}
                                             : {1'b0, bus.rx_data_i};
            state_q <= StData;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            acc_q   <= sum_next;
`endif
          end
          StData: begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= addr_q;
            mem_data_q <= bus.rx_data_i;
            addr_q     <= addr_q + ADDR_WIDTH'(1);
            cnt_q      <= cnt_q - (DATA_WIDTH + 1)'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            acc_q      <= sum_next;
            if (cnt_q == 1) state_q <= StCheck;
`else
            if (cnt_q == 1) begin
              state_q    <= StIdle;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end
`endif
          end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          StCheck: begin
            state_q <= StIdle;
            if (sum_next == '0) begin
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end
`endif
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a frame-level model.
module tb_program_loader;

  localparam logic [7:0] Header = 8'hA5;
  localparam int KIgn = 0, KHdr = 1, KFld = 2, KPay = 3, KChk = 4;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          lastpl;
    bit          fin;
    bit          ok;
  } ann_t;

  logic clk = 1'b0;
  logic reset;
  program_loader_if bus ();

  program_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  ann_t annq[$];
  logic [7:0] mem [0:65535];
  logic [7:0] pl [0:255];
  int nwrites = 0;
  int ndone = 0;

  // Expected outputs for the current cycle
  logic        exp_we = 0, exp_done = 0, exp_err = 0, exp_hold = 1, exp_busy = 0, exp_ready = 1;
  logic [15:0] exp_addr = 0;
  logic [7:0]  exp_data = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: applies last edge's event to the model, then checks every output.
  initial begin : cmp
    bit   pend_rst, pend_acc, started;
    ann_t pa;
    pend_rst = 0; pend_acc = 0; started = 0;
    forever begin
      @(negedge clk);
      if (pend_rst) begin
        exp_we = 0; exp_done = 0; exp_err = 0; exp_hold = 1; exp_busy = 0; exp_ready = 1;
        exp_addr = 0; exp_data = 0;
        started = 1;
      end else begin
        exp_we = 0; exp_done = 0; exp_ready = 1;
        if (pend_acc) begin
          if (pa.kind == KHdr) begin
            exp_busy = 1; exp_hold = 1; exp_err = 0;
          end
          if (pa.kind == KPay) begin
            exp_we = 1; exp_addr = pa.addr; exp_data = pa.data;
            if (!pa.lastpl) exp_ready = 0;
          end
          if (pa.fin) begin
            exp_busy = 0;
            if (pa.ok) begin exp_done = 1; exp_hold = 0; end
            else exp_err = 1;
          end
        end
      end
      if (started) begin
        chk("cyc_we",    32'(bus.mem_we_o),     32'(exp_we));
        chk("cyc_addr",  32'(bus.mem_addr_o),   32'(exp_addr));
        chk("cyc_data",  32'(bus.mem_data_o),   32'(exp_data));
        chk("cyc_done",  32'(bus.load_done_o),  32'(exp_done));
        chk("cyc_err",   32'(bus.load_error_o), 32'(exp_err));
        chk("cyc_hold",  32'(bus.cpu_hold_o),   32'(exp_hold));
        chk("cyc_busy",  32'(bus.busy_o),       32'(exp_busy));
        chk("cyc_ready", 32'(bus.rx_ready_o),   32'(exp_ready));
      end
      if (bus.mem_we_o === 1'b1) begin
        mem[bus.mem_addr_o] = bus.mem_data_o;
        nwrites++;
      end
      if (bus.load_done_o === 1'b1) ndone++;
      pend_rst = (reset === 1'b1);
      pend_acc = !pend_rst && (bus.rx_valid_i === 1'b1) && (bus.rx_ready_o === 1'b1);
      if (pend_acc) begin
        if (annq.size() == 0) begin
          checks++; errors++;
          $display("FAIL accept_unexpected: actual byte %0h accepted, required none", bus.rx_data_i);
          pend_acc = 0;
        end else begin
          pa = annq.pop_front();
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input ann_t a);
    bit r;
    int n;
    annq.push_back(a);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    n = 0;
    forever begin
      @(negedge clk);
      r = (bus.rx_ready_o === 1'b1);
      @(posedge clk);
      if (r) break;
      n++;
      if (n > 100) begin
        errors++;
        $display("FAIL accept_timeout: actual ready low 100 cycles, required accept of %0h", b);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "stalled");
      end
    end
    #1;
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_simple(input logic [7:0] b, input int kind);
    ann_t a;
    a = '{kind: kind, addr: 16'h0, data: 8'h0, lastpl: 1'b0, fin: 1'b0, ok: 1'b0};
    send_byte(b, a);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends a frame built from pl[0..n-1]; n == 256 is sent as length byte 00.
  task automatic send_frame(input logic [15:0] a, input int n, input bit bad);
    logic [7:0] sum, lenb;
    ann_t an;
    lenb = 8'(n);
    sum  = a[15:8] + a[7:0] + lenb;
    send_simple(Header, KHdr);
    send_simple(a[15:8], KFld);
    send_simple(a[7:0], KFld);
    send_simple(lenb, KFld);
    for (int i = 0; i < n; i++) begin
      sum = sum + pl[i];
      an.kind = KPay; an.addr = a + 16'(i); an.data = pl[i];
      an.lastpl = (i == n - 1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      an.fin = 1'b0;
`else
      an.fin = (i == n - 1);
`endif
      an.ok = 1'b1;
      send_byte(pl[i], an);
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 2));
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    an.kind = KChk; an.addr = 0; an.data = 0; an.lastpl = 0; an.fin = 1; an.ok = !bad;
    send_byte(8'(8'h00 - sum) + (bad ? 8'h01 : 8'h00), an);
`else
    if (bad) idle(1);
`endif
  endtask

  int base;

  initial begin
    reset = 1'b1;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_hold",  32'(bus.cpu_hold_o), 32'd1);
    chk("rst_ready", 32'(bus.rx_ready_o), 32'd1);
    chk("rst_busy",  32'(bus.busy_o),     32'd0);
    chk("rst_addr",  32'(bus.mem_addr_o), 32'd0);
    idle(1);

    // Noise before a header
    send_simple(8'h00, KIgn);
    send_simple(8'h7F, KIgn);
    idle(2);
    chk("noise_nowrites", 32'(nwrites), 32'd0);

    pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
    send_frame(16'hF000, 3, 0);
    idle(3);
    chk("f1_mem0", 32'(mem[16'hF000]), 32'hAA);
    chk("f1_mem1", 32'(mem[16'hF001]), 32'hBB);
    chk("f1_mem2", 32'(mem[16'hF002]), 32'hCC);
    chk("f1_done", 32'(ndone), 32'd1);
    chk("f1_hold", 32'(bus.cpu_hold_o), 32'd0);
    base = nwrites;
    send_simple(8'h42, KIgn);
    idle(2);
    chk("trailing_ignored", 32'(nwrites - base), 32'd0);

    pl[0] = 8'h11; pl[1] = 8'h22;
    send_frame(16'hFFFF, 2, 0);
    idle(3);
    chk("wrap_ffff", 32'(mem[16'hFFFF]), 32'h11);
    chk("wrap_0000", 32'(mem[16'h0000]), 32'h22);
    chk("wrap_done", 32'(ndone), 32'd2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
    base = nwrites;
    send_frame(16'hF000, 3, 1);
    idle(3);
    chk("bad_writes", 32'(nwrites - base), 32'd3);
    chk("bad_error",  32'(bus.load_error_o), 32'd1);
    chk("bad_hold",   32'(bus.cpu_hold_o), 32'd1);
    chk("bad_nodone", 32'(ndone), 32'd2);
    send_frame(16'hF000, 3, 0);
    idle(3);
    chk("recover_err",  32'(bus.load_error_o), 32'd0);
    chk("recover_hold", 32'(bus.cpu_hold_o), 32'd0);
`endif

    // Reset mid-frame, then stray bytes
    send_simple(Header, KHdr);
    send_simple(8'hF0, KFld);
    @(posedge clk); #1 reset = 1'b1;
    idle(2);
    reset = 1'b0;
    base = nwrites;
    send_simple(8'h00, KIgn);
    send_simple(8'h03, KIgn);
    send_simple(8'hAA, KIgn);
    idle(3);
    chk("rst_mid_nowrites", 32'(nwrites - base), 32'd0);
    chk("rst_mid_hold",     32'(bus.cpu_hold_o), 32'd1);

    // Length 0 means 256; last byte is A5 to exercise header-as-data
    for (int i = 0; i < 256; i++) pl[i] = 8'(i) ^ 8'h5A;
    base = nwrites;
    send_frame(16'h1000, 256, 0);
    idle(3);
    chk("len0_writes", 32'(nwrites - base), 32'd256);
    chk("len0_first",  32'(mem[16'h1000]), 32'h5A);
    chk("len0_last",   32'(mem[16'h10FF]), 32'hA5);

    for (int f = 0; f < 15; f++) begin
      int  nn, noise;
      bit  bad;
      logic [7:0] nb;
      noise = $urandom_range(0, 2);
      for (int k = 0; k < noise; k++) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == Header) nb = 8'h00;
        send_simple(nb, KIgn);
      end
      nn = $urandom_range(1, 12);
      for (int i = 0; i < nn; i++)
        pl[i] = ($urandom_range(0, 7) == 0) ? Header : 8'($urandom_range(0, 255));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 3) == 0);
`else
      bad = 1'b0;
`endif
      send_frame(16'($urandom_range(0, 65535)), nn, bad);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("queue_drained", 32'(annq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
